// File: rtl/nes_cpu_run_controller.sv
// Gates the 6502 clock enable for the debugger: bounded steps, run-to-break, halt.
// Reports completion, stop reason and the number of enabled cycles.
module nes_cpu_run_controller #(
   parameter int COUNT_WIDTH = 16,
   parameter int CYCLE_WIDTH = 32
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_cmd_valid,
   output logic                   o_cmd_ready,
   input  logic [1:0]             i_cmd_op,
   input  logic [COUNT_WIDTH-1:0] i_cmd_count,
   input  logic                   i_bp_en,
   input  logic [15:0]            i_bp_address,
   input  logic                   i_cpu_sync,
   input  logic [15:0]            i_cpu_address,
   output logic                   o_cpu_clk_en,
   output logic                   o_running,
   output logic                   o_done,
   output logic [1:0]             o_stop_reason,
   output logic                   o_cmd_error,
   output logic [CYCLE_WIDTH-1:0] o_cycle_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_t;

   localparam logic [1:0] OP_STEP = 2'd0;
   localparam logic [1:0] OP_RUN  = 2'd1;
   localparam logic [1:0] OP_HALT = 2'd2;

   localparam logic [1:0] RSN_NONE  = 2'd0;
   localparam logic [1:0] RSN_COUNT = 2'd1;
   localparam logic [1:0] RSN_BREAK = 2'd2;
   localparam logic [1:0] RSN_HALT  = 2'd3;

   localparam logic [COUNT_WIDTH-1:0] CNT_ONE = 1;
   localparam logic [CYCLE_WIDTH-1:0] CYC_ONE = 1;

   state_t                 state;
   logic [COUNT_WIDTH-1:0] remaining;
   logic                   unlimited;
   logic                   break_armed;
   logic                   accept;
   logic                   in_run;
   logic                   hit;
   logic                   halt;

   assign in_run      = (state == RUN);
   assign o_cmd_ready = (state == IDLE) | in_run;
   assign o_running   = in_run;
   assign accept      = i_cmd_valid & o_cmd_ready;

   assign hit = in_run & break_armed & i_bp_en & i_cpu_sync
              & (i_cpu_address == i_bp_address);
   assign halt = in_run & accept & (i_cmd_op == OP_HALT);

   // Combinational so a halt or breakpoint suppresses the very cycle it is seen in.
   assign o_cpu_clk_en = in_run & ~hit & ~halt;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= IDLE;
         remaining     <= '0;
         unlimited     <= 1'b0;
         break_armed   <= 1'b0;
         o_done        <= 1'b0;
         o_stop_reason <= RSN_NONE;
         o_cmd_error   <= 1'b0;
         o_cycle_count <= '0;
      end else begin
         o_done      <= 1'b0;
         o_cmd_error <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  remaining     <= i_cmd_count;
                  o_cycle_count <= '0;
                  o_stop_reason <= RSN_NONE;
                  break_armed   <= 1'b0;
                  unlimited     <= (i_cmd_op == OP_RUN)
                                 & (i_cmd_count == '0);
                  unique case (i_cmd_op)
                     OP_STEP: begin
                        if (i_cmd_count == '0) begin
                           state         <= STOP;
                           o_stop_reason <= RSN_COUNT;
                           o_done        <= 1'b1;
                        end else begin
                           state <= RUN;
                        end
                     end
                     OP_RUN:  state <= RUN;
                     OP_HALT: begin
                        state         <= STOP;
                        o_stop_reason <= RSN_HALT;
                        o_done        <= 1'b1;
                     end
                     default: o_cmd_error <= 1'b1;
                  endcase
               end
            end
            RUN: begin
               o_cmd_error <= accept & (i_cmd_op != OP_HALT);
               if (halt) begin
                  state         <= STOP;
                  o_stop_reason <= RSN_HALT;
                  o_done        <= 1'b1;
               end else if (hit) begin
                  state         <= STOP;
                  o_stop_reason <= RSN_BREAK;
                  o_done        <= 1'b1;
               end else begin
                  // Arming after the first enabled cycle steps over a parked breakpoint.
                  break_armed <= 1'b1;
                  if (~&o_cycle_count)
                     o_cycle_count <= o_cycle_count + CYC_ONE;
                  if (!unlimited) begin
                     remaining <= remaining - CNT_ONE;
                     if (remaining == CNT_ONE) begin
                        state         <= STOP;
                        o_stop_reason <= RSN_COUNT;
                        o_done        <= 1'b1;
                     end
                  end
               end
            end
            STOP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nes_cpu_run_controller.sv
// Bench for nes_cpu_run_controller: cycle table through a scoreboard queue,
// plus hand-driven asynchronous reset sequences.
module tb_nes_cpu_run_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_count;
   logic        bp_en;
   logic [15:0] bp_address;
   logic        cpu_sync;
   logic [15:0] cpu_address;
   logic        cpu_clk_en;
   logic        running;
   logic        done;
   logic [1:0]  stop_reason;
   logic        cmd_error;
   logic [31:0] cycle_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   nes_cpu_run_controller #(.COUNT_WIDTH(16), .CYCLE_WIDTH(32)) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_cmd_valid   (cmd_valid),
      .o_cmd_ready   (cmd_ready),
      .i_cmd_op      (cmd_op),
      .i_cmd_count   (cmd_count),
      .i_bp_en       (bp_en),
      .i_bp_address  (bp_address),
      .i_cpu_sync    (cpu_sync),
      .i_cpu_address (cpu_address),
      .o_cpu_clk_en  (cpu_clk_en),
      .o_running     (running),
      .o_done        (done),
      .o_stop_reason (stop_reason),
      .o_cmd_error   (cmd_error),
      .o_cycle_count (cycle_count)
   );

   typedef struct {
      logic        valid;
      logic [1:0]  op;
      logic [15:0] cnt;
      logic        bpe;
      logic [15:0] bpa;
      logic        sync;
      logic [15:0] addr;
      logic        en;
      logic        run;
      logic        dn;
      logic [1:0]  rsn;
      logic        err;
      logic        rdy;
      logic [31:0] cyc;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic vec_t v(
      logic valid, logic [1:0] op, logic [15:0] cnt,
      logic bpe, logic [15:0] bpa, logic sync, logic [15:0] addr,
      logic en, logic run, logic dn, logic [1:0] rsn,
      logic err, logic rdy, logic [31:0] cyc);
      vec_t r;
      r.valid = valid; r.op = op; r.cnt = cnt;
      r.bpe = bpe; r.bpa = bpa; r.sync = sync; r.addr = addr;
      r.en = en; r.run = run; r.dn = dn; r.rsn = rsn;
      r.err = err; r.rdy = rdy; r.cyc = cyc;
      return r;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(logic valid, logic [1:0] op, logic [15:0] cnt);
      cmd_valid = valid;
      cmd_op    = op;
      cmd_count = cnt;
   endtask

   initial begin
      vec_t e;
      rst_n = 1'b0;
      drive(1'b0, 2'd0, 16'd0);
      bp_en = 1'b0; bp_address = 16'h0;
      cpu_sync = 1'b0; cpu_address = 16'h0;

      // reserved op in IDLE: error pulse only
      tbl.push_back(v(1,3,0, 0,16'h0,0,16'h0,     0,0,0,0,0,1,0));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     0,0,0,0,1,1,0));
      // STEP_N 3
      tbl.push_back(v(1,0,3, 0,16'h0,0,16'h0,     0,0,0,0,0,1,0));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     1,1,0,0,0,1,0));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     1,1,0,0,0,1,1));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     1,1,0,0,0,1,2));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     0,0,1,1,0,0,3));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     0,0,0,1,0,1,3));
      // RUN_TO_BREAK unlimited, bp C004 on 5th cycle
      tbl.push_back(v(1,1,0, 1,16'hC004,0,16'hC000, 0,0,0,1,0,1,3));
      tbl.push_back(v(0,0,0, 1,16'hC004,1,16'hC000, 1,1,0,0,0,1,0));
      tbl.push_back(v(0,0,0, 1,16'hC004,1,16'hC001, 1,1,0,0,0,1,1));
      tbl.push_back(v(0,0,0, 1,16'hC004,1,16'hC002, 1,1,0,0,0,1,2));
      tbl.push_back(v(0,0,0, 1,16'hC004,1,16'hC003, 1,1,0,0,0,1,3));
      tbl.push_back(v(0,0,0, 1,16'hC004,1,16'hC004, 0,1,0,0,0,1,4));
      tbl.push_back(v(0,0,0, 1,16'hC004,1,16'hC004, 0,0,1,2,0,0,4));
      // restart parked on the breakpoint
      tbl.push_back(v(1,1,0, 1,16'hC004,1,16'hC004, 0,0,0,2,0,1,4));
      tbl.push_back(v(0,0,0, 1,16'hC004,1,16'hC004, 1,1,0,0,0,1,0));
      tbl.push_back(v(0,0,0, 1,16'hC004,0,16'hC005, 1,1,0,0,0,1,1));
      tbl.push_back(v(0,0,0, 1,16'hC004,1,16'hC004, 0,1,0,0,0,1,2));
      tbl.push_back(v(0,0,0, 1,16'hC004,0,16'hC004, 0,0,1,2,0,0,2));
      // unlimited run, STEP_N rejected, then HALT
      tbl.push_back(v(1,1,0, 0,16'h0,0,16'h0,     0,0,0,2,0,1,2));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     1,1,0,0,0,1,0));
      tbl.push_back(v(1,0,5, 0,16'h0,0,16'h0,     1,1,0,0,0,1,1));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     1,1,0,0,1,1,2));
      tbl.push_back(v(1,2,0, 0,16'h0,0,16'h0,     0,1,0,0,0,1,3));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     0,0,1,3,0,0,3));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     0,0,0,3,0,1,3));
      // breakpoint hit coincides with remaining==1
      tbl.push_back(v(1,0,2, 1,16'hC010,1,16'hC00F, 0,0,0,3,0,1,3));
      tbl.push_back(v(0,0,0, 1,16'hC010,1,16'hC00F, 1,1,0,0,0,1,0));
      tbl.push_back(v(0,0,0, 1,16'hC010,1,16'hC010, 0,1,0,0,0,1,1));
      tbl.push_back(v(0,0,0, 1,16'hC010,1,16'hC010, 0,0,1,2,0,0,1));
      // STEP_N 0, and a command offered during STOP is ignored
      tbl.push_back(v(1,0,0, 0,16'h0,0,16'h0,     0,0,0,2,0,1,1));
      tbl.push_back(v(1,1,0, 0,16'h0,0,16'h0,     0,0,1,1,0,0,0));
      tbl.push_back(v(0,0,0, 0,16'h0,0,16'h0,     0,0,0,1,0,1,0));

      #12;
      chk("reset en",    cpu_clk_en,  0);
      chk("reset run",   running,     0);
      chk("reset done",  done,        0);
      chk("reset rsn",   stop_reason, 0);
      chk("reset err",   cmd_error,   0);
      chk("reset rdy",   cmd_ready,   1);
      chk("reset cyc",   cycle_count, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(posedge clk);
         #1;
         drive(tbl[i].valid, tbl[i].op, tbl[i].cnt);
         bp_en       = tbl[i].bpe;
         bp_address  = tbl[i].bpa;
         cpu_sync    = tbl[i].sync;
         cpu_address = tbl[i].addr;
         sb.push_back(tbl[i]);
         @(negedge clk);
         e = sb.pop_front();
         chk($sformatf("r%0d en",   i), cpu_clk_en,  e.en);
         chk($sformatf("r%0d run",  i), running,     e.run);
         chk($sformatf("r%0d done", i), done,        e.dn);
         chk($sformatf("r%0d rsn",  i), stop_reason, e.rsn);
         chk($sformatf("r%0d err",  i), cmd_error,   e.err);
         chk($sformatf("r%0d rdy",  i), cmd_ready,   e.rdy);
         chk($sformatf("r%0d cyc",  i), cycle_count, e.cyc);
      end

      // reset mid-run
      bp_en = 1'b0; cpu_sync = 1'b0;
      @(posedge clk); #1;
      drive(1'b1, 2'd0, 16'd100);
      @(posedge clk); #1;
      drive(1'b0, 2'd0, 16'd0);
      @(negedge clk);
      chk("mid en", cpu_clk_en, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("arst en",  cpu_clk_en, 0);
      chk("arst run", running,    0);
      chk("arst rdy", cmd_ready,  1);
      @(negedge clk);
      chk("arst cyc", cycle_count, 0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rel rdy", cmd_ready,  1);
      chk("rel run", running,    0);
      chk("rel en",  cpu_clk_en, 0);

      // reset while o_done is high
      @(posedge clk); #1;
      drive(1'b1, 2'd0, 16'd1);
      @(posedge clk); #1;
      drive(1'b0, 2'd0, 16'd0);
      @(negedge clk);
      chk("one en", cpu_clk_en, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("one done", done, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst done", done,        0);
      chk("arst rsn",  stop_reason, 0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rel2 rdy", cmd_ready, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
